// File: rtl/aes_seq_pkg.sv
// rtl/aes_seq_pkg.sv - shared types, states and staging addresses for the AES job sequencer
package aes_seq_pkg;

   typedef logic [127:0] aes_block_t;

   typedef enum logic [2:0] {
      IDLE,
      KEYLOAD,
      KEYWAIT,
      START,
      WAIT_DONE,
      RESULT,
      ERROR
   } aes_seq_state_t;

   localparam logic [2:0] ADDR_KEY0 = 3'd0;
   localparam logic [2:0] ADDR_KEY1 = 3'd1;
   localparam logic [2:0] ADDR_KEY2 = 3'd2;
   localparam logic [2:0] ADDR_KEY3 = 3'd3;
   localparam logic [2:0] ADDR_BLK0 = 3'd4;
   localparam logic [2:0] ADDR_BLK1 = 3'd5;
   localparam logic [2:0] ADDR_BLK2 = 3'd6;
   localparam logic [2:0] ADDR_BLK3 = 3'd7;

   // Word 0 is the most significant word of the 128-bit value.
   function automatic aes_block_t put_word(input aes_block_t cur, input logic [1:0] idx,
                                           input logic [31:0] w);
      aes_block_t r;
      r = cur;
      case (idx)
         2'd0:    r[127:96] = w;
         2'd1:    r[95:64]  = w;
         2'd2:    r[63:32]  = w;
         default: r[31:0]   = w;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_job_sequencer_if.sv
// rtl/aes_job_sequencer_if.sv - host-side staging, command and result signals of the sequencer
interface aes_job_sequencer_if;
   import aes_seq_pkg::*;

   logic        cfg_wr_en;
   logic [2:0]  cfg_wr_addr;
   logic [31:0] cfg_wr_data;
   logic        cmd_valid;
   logic        cmd_rekey;
   logic        cmd_ready;
   logic        res_valid;
   logic        res_ready;
   aes_block_t  res_data;
   logic        busy;
   logic        err_timeout;
   logic        err_clr;

   modport master (
      output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cmd_valid, cmd_rekey, res_ready, err_clr,
      input  cmd_ready, res_valid, res_data, busy, err_timeout
   );

   modport slave (
      input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cmd_valid, cmd_rekey, res_ready, err_clr,
      output cmd_ready, res_valid, res_data, busy, err_timeout
   );

endinterface

// File: rtl/aes_seq_downcounter.sv
// rtl/aes_seq_downcounter.sv - loadable down-counter with zero flag, shared by key wait and watchdog
module aes_seq_downcounter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // Load has priority; counting stops at zero rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/aes_job_sequencer.sv
// rtl/aes_job_sequencer.sv - sequences one AES-128 core job; AES_SEQ_TIMEOUT_EN enables the done watchdog
module aes_job_sequencer
   import aes_seq_pkg::*;
#(
   parameter int KEY_SETUP_CYCLES = 10,
   parameter int TIMEOUT_CYCLES   = 64
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   aes_job_sequencer_if.slave    host,
   output aes_block_t            aes_key,
   output logic                  aes_key_load,
   output aes_block_t            aes_din,
   output logic                  aes_start,
   input  logic                  aes_done,
   input  aes_block_t            aes_dout
);

   // One counter covers both waits, so it is sized for the longer of the two.
   localparam int CNT_MAX = (KEY_SETUP_CYCLES > TIMEOUT_CYCLES) ? KEY_SETUP_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] KEY_LOAD_VAL = CNT_W'(KEY_SETUP_CYCLES - 1);

   aes_seq_state_t   state;
   aes_seq_state_t   next_state;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_en;
   logic             cnt_zero;
   logic             ready_q;
   aes_block_t       res_q;

   aes_seq_downcounter #(.WIDTH(CNT_W)) u_cnt (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .load     (cnt_load),
      .load_val (cnt_val),
      .en       (cnt_en),
      .zero     (cnt_zero)
   );

   // State register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and wait-counter control.
   always_comb begin
      next_state = state;
      cnt_load   = 1'b0;
      cnt_val    = KEY_LOAD_VAL;
      cnt_en     = 1'b0;
      case (state)
         IDLE: begin
            if (host.cmd_valid && host.cmd_ready) begin
               next_state = host.cmd_rekey ? KEYLOAD : START;
            end
         end
         KEYLOAD: begin
            cnt_load   = 1'b1;
            next_state = KEYWAIT;
         end
         KEYWAIT: begin
            cnt_en = 1'b1;
            if (cnt_zero) begin
               next_state = START;
            end
         end
         START: begin
`ifdef AES_SEQ_TIMEOUT_EN
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
            next_state = WAIT_DONE;
         end
         WAIT_DONE: begin
            // A done arriving on the last allowed cycle still wins over the timeout.
            if (aes_done) begin
               next_state = RESULT;
            end
`ifdef AES_SEQ_TIMEOUT_EN
            else if (cnt_zero) begin
               next_state = ERROR;
            end
            cnt_en = 1'b1;
`endif
         end
         RESULT: begin
            if (host.res_ready) begin
               next_state = IDLE;
            end
         end
         ERROR: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // cmd_ready is registered so it stays low while reset is asserted.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= (next_state == IDLE);
      end
   end

   // Staging registers accept host writes only while idle.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aes_key <= '0;
         aes_din <= '0;
      end else if (host.cfg_wr_en && (state == IDLE)) begin
         if (host.cfg_wr_addr[2]) begin
            aes_din <= put_word(aes_din, host.cfg_wr_addr[1:0], host.cfg_wr_data);
         end else begin
            aes_key <= put_word(aes_key, host.cfg_wr_addr[1:0], host.cfg_wr_data);
         end
      end
   end

   // Capture the core output only while a job is waiting for it.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         res_q <= '0;
      end else if ((state == WAIT_DONE) && aes_done) begin
         res_q <= aes_dout;
      end
   end

`ifdef AES_SEQ_TIMEOUT_EN
   logic err_q;

   // Sticky timeout flag; a new timeout beats a simultaneous clear.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         err_q <= 1'b0;
      end else if (next_state == ERROR) begin
         err_q <= 1'b1;
      end else if (host.err_clr) begin
         err_q <= 1'b0;
      end
   end

   assign host.err_timeout = err_q;
`else
   assign host.err_timeout = 1'b0;
`endif

   assign host.cmd_ready = ready_q;
   assign host.res_valid = (state == RESULT);
   assign host.res_data  = res_q;
   assign host.busy      = (state != IDLE);
   assign aes_key_load   = (state == KEYLOAD);
   assign aes_start      = (state == START);

endmodule

// File: tb/tb_aes_job_sequencer.sv
// tb/tb_aes_job_sequencer.sv - table-driven self-checking bench for aes_job_sequencer
module tb_aes_job_sequencer;
   import aes_seq_pkg::*;

   localparam int KEY_SETUP = 10;
   localparam int TIMEOUT   = 64;

   logic       ACLK = 1'b0;
   logic       ARESETN = 1'b0;
   aes_block_t aes_key, aes_din, aes_dout;
   logic       aes_key_load, aes_start, aes_done;

   aes_job_sequencer_if host();

   aes_job_sequencer #(.KEY_SETUP_CYCLES(KEY_SETUP), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .host         (host),
      .aes_key      (aes_key),
      .aes_key_load (aes_key_load),
      .aes_din      (aes_din),
      .aes_start    (aes_start),
      .aes_done     (aes_done),
      .aes_dout     (aes_dout)
   );

   always #5 ACLK = ~ACLK;

   int errors = 0;
   int checks = 0;

   aes_block_t fips_key, fips_pt, fips_ct, k2, b1, b2, blk_s;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bench core: key latched on key_load, done after core_lat cycles of WAIT_DONE.
   int         core_lat  = 1;
   bit         core_hang = 0;
   int         core_cnt  = 0;
   aes_block_t core_key  = '0;
   aes_block_t core_din  = '0;

   function automatic aes_block_t core_fn(input aes_block_t k, input aes_block_t d);
      return ((k == fips_key) && (d == fips_pt)) ? fips_ct : (d ^ k);
   endfunction

   initial begin
      aes_done = 1'b0;
      aes_dout = '0;
      forever begin
         @(negedge ACLK);
         aes_done = 1'b0;
         if (aes_key_load) core_key = aes_key;
         if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0 && !core_hang) begin
               aes_done = 1'b1;
               aes_dout = core_fn(core_key, core_din);
            end
         end
         if (aes_start) begin
            core_din = aes_din;
            core_cnt = core_lat;
         end
      end
   end

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      host.cfg_wr_en   = 1'b1;
      host.cfg_wr_addr = a;
      host.cfg_wr_data = d;
      @(negedge ACLK);
      host.cfg_wr_en = 1'b0;
   endtask

   task automatic stage(input aes_block_t k, input aes_block_t b);
      for (int i = 0; i < 4; i++) wr(3'(i), k[127-32*i -: 32]);
      for (int i = 0; i < 4; i++) wr(3'(4 + i), b[127-32*i -: 32]);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " cmd_ready"}, host.cmd_ready, 0);
      check({tag, " aes_key"}, aes_key, 0);
      check({tag, " aes_key_load"}, aes_key_load, 0);
      check({tag, " aes_din"}, aes_din, 0);
      check({tag, " aes_start"}, aes_start, 0);
      check({tag, " res_valid"}, host.res_valid, 0);
      check({tag, " res_data"}, host.res_data, 0);
      check({tag, " busy"}, host.busy, 0);
      check({tag, " err_timeout"}, host.err_timeout, 0);
   endtask

   // Issue one command at a negedge, run to res_valid, optionally backpressure, then hand-shake.
   task automatic do_job(input string tag, input logic rekey, input int lat, input int hold,
                         input bit busy_wr, input aes_block_t exp_res, input int exp_lat,
                         input int exp_kl);
      int cnt, kl, kl_at, st_at;
      bit rdy_seen;
      core_lat = lat;
      check({tag, " cmd_ready before"}, host.cmd_ready, 1);
      host.cmd_valid = 1'b1;
      host.cmd_rekey = rekey;
      @(negedge ACLK);
      host.cmd_valid = 1'b0;
      host.cmd_rekey = 1'b0;
      cnt = 1; kl = 0; kl_at = 0; st_at = 0; rdy_seen = 0;
      while (cnt < 400 && !host.res_valid) begin
         if (aes_key_load) begin kl++; kl_at = cnt; end
         if (aes_start) st_at = cnt;
         if (host.cmd_ready) rdy_seen = 1;
         if (busy_wr && cnt == 3) begin
            host.cfg_wr_en   = 1'b1;
            host.cfg_wr_addr = ADDR_BLK0;
            host.cfg_wr_data = 32'hDEADBEEF;
         end else begin
            host.cfg_wr_en = 1'b0;
         end
         @(negedge ACLK);
         cnt++;
      end
      host.cfg_wr_en = 1'b0;
      check({tag, " latency"}, cnt, exp_lat);
      check({tag, " key_load pulses"}, kl, exp_kl);
      check({tag, " cmd_ready while busy"}, rdy_seen, 0);
      check({tag, " res_data"}, host.res_data, exp_res);
      if (exp_kl == 1) check({tag, " KEYWAIT cycles"}, st_at - kl_at - 1, KEY_SETUP);
      for (int h = 0; h < hold; h++) begin
         check({tag, " hold res_valid"}, host.res_valid, 1);
         check({tag, " hold res_data"}, host.res_data, exp_res);
         host.cmd_valid = (h == 5);
         host.cmd_rekey = (h == 5);
         @(negedge ACLK);
      end
      host.cmd_valid = 1'b0;
      host.cmd_rekey = 1'b0;
      host.res_ready = 1'b1;
      check({tag, " cmd_ready in handshake"}, host.cmd_ready, 0);
      @(negedge ACLK);
      host.res_ready = 1'b0;
      check({tag, " res_valid after"}, host.res_valid, 0);
      check({tag, " cmd_ready after"}, host.cmd_ready, 1);
      check({tag, " busy after"}, host.busy, 0);
   endtask

   typedef struct {
      logic       rekey;
      aes_block_t key;
      aes_block_t blk;
      int         lat;
      aes_block_t exp_res;
      int         exp_lat;
      int         exp_kl;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int cnt;
      bit bad;
      fips_key = 128'h000102030405060708090a0b0c0d0e0f;
      fips_pt  = 128'h00112233445566778899aabbccddeeff;
      fips_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      k2       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      b1       = 128'h3243f6a8885a308d313198a2e0370734;
      b2       = 128'h6bc1bee22e409f96e93d7e117393172a;
      blk_s    = {fips_pt[127:32], 32'h11111111};

      // Rekey rows: 1 KEYLOAD + 10 KEYWAIT + 1 START + lat + result cycle.
      vecs[0] = '{1'b1, fips_key, fips_pt, 5, fips_ct,         18, 1};
      vecs[1] = '{1'b0, k2,       b1,      3, b1 ^ fips_key,    5, 0};
      vecs[2] = '{1'b1, k2,       b2,      1, b2 ^ k2,         14, 1};
      vecs[3] = '{1'b0, k2,       fips_pt, 7, fips_pt ^ k2,     9, 0};

      host.cfg_wr_en = 0; host.cfg_wr_addr = 0; host.cfg_wr_data = 0;
      host.cmd_valid = 0; host.cmd_rekey = 0; host.res_ready = 0; host.err_clr = 0;

      repeat (2) @(negedge ACLK);
      check_all_zero("reset");
      ARESETN = 1'b1;
      @(negedge ACLK);
      check("post-reset cmd_ready", host.cmd_ready, 1);

      for (int v = 0; v < 4; v++) begin
         stage(vecs[v].key, vecs[v].blk);
         check($sformatf("vec%0d staged key", v), aes_key, vecs[v].key);
         check($sformatf("vec%0d staged blk", v), aes_din, vecs[v].blk);
         do_job($sformatf("vec%0d", v), vecs[v].rekey, vecs[v].lat, 0, 0,
                vecs[v].exp_res, vecs[v].exp_lat, vecs[v].exp_kl);
      end

      do_job("backpressure", 0, 4, 20, 0, fips_pt ^ k2, 6, 0);

      host.cfg_wr_en   = 1'b1;
      host.cfg_wr_addr = ADDR_BLK3;
      host.cfg_wr_data = 32'h11111111;
      do_job("write with cmd", 0, 2, 0, 0, blk_s ^ k2, 4, 0);

      do_job("busy write", 0, 6, 0, 1, blk_s ^ k2, 8, 0);
      check("busy write dropped", aes_din, blk_s);
      do_job("after busy write", 0, 2, 0, 0, blk_s ^ k2, 4, 0);

`ifdef AES_SEQ_TIMEOUT_EN
      core_hang = 1;
      host.cmd_valid = 1'b1;
      @(negedge ACLK);
      host.cmd_valid = 1'b0;
      cnt = 1;
      while (cnt < 300 && !host.err_timeout) begin
         @(negedge ACLK);
         cnt++;
      end
      check("timeout cycle", cnt, 1 + TIMEOUT + 1);
      check("timeout res_valid", host.res_valid, 0);
      check("timeout busy in ERROR", host.busy, 1);
      @(negedge ACLK);
      check("timeout back to idle", host.busy, 0);
      check("timeout cmd_ready", host.cmd_ready, 1);
      check("timeout sticky", host.err_timeout, 1);
      host.err_clr = 1'b1;
      @(negedge ACLK);
      host.err_clr = 1'b0;
      check("err_clr", host.err_timeout, 0);
      core_hang = 0;
      core_cnt  = 0;
      do_job("done on last cycle", 0, TIMEOUT, 0, 0, blk_s ^ k2, TIMEOUT + 2, 0);
      check("no error on last-cycle done", host.err_timeout, 0);
`else
      do_job("long core", 0, 100, 0, 0, blk_s ^ k2, 102, 0);
      check("no timeout flag", host.err_timeout, 0);
`endif

      host.cmd_valid = 1'b1;
      host.cmd_rekey = 1'b1;
      @(negedge ACLK);
      host.cmd_valid = 1'b0;
      host.cmd_rekey = 1'b0;
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b0;
      #1;
      check_all_zero("mid-job reset");
      @(negedge ACLK);
      ARESETN = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge ACLK);
         if (host.res_valid || aes_start || aes_key_load) bad = 1;
      end
      check("no activity after reset", bad, 0);
      check("idle after reset", host.busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
